// File: rtl/text_load_sequencer_pkg.sv
// Shared types and constants for the text RAM load sequencer.
package text_load_pkg;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        LOAD    = 3'd3,
        RESTART = 3'd4,
        ERROR   = 3'd5
    } seq_state_t;

    localparam int START_DELAY_W = 4;

endpackage

// File: rtl/text_load_sequencer_if.sv
// Ring token, upload stream and text RAM write bundle of the load sequencer.
interface text_load_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  fetch_req;
    logic                  ram_req;
    logic                  core_start;
    logic                  pc_clear;
    logic                  core_hold;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  load_last;
    logic                  load_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] load_csum;
    logic                  busy;
    logic                  overflow;
    logic                  csum_err;

    modport slave (
        input  fetch_req, load_valid, load_word, load_last, load_csum,
        output ram_req, core_start, pc_clear, core_hold, load_ready,
               ram_we, ram_waddr, ram_wdata, busy, overflow, csum_err
    );

    modport master (
        output fetch_req, load_valid, load_word, load_last, load_csum,
        input  ram_req, core_start, pc_clear, core_hold, load_ready,
               ram_we, ram_waddr, ram_wdata, busy, overflow, csum_err
    );
endinterface

// File: rtl/text_load_sequencer_start_pulser.sv
// Delay counter that fires after START_DELAY enabled cycles and emits a registered one-cycle pulse.
module start_pulser
    import text_load_pkg::*;
#(
    parameter int START_DELAY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic fire,
    output logic pulse
);
    localparam logic [START_DELAY_W-1:0] LAST_CNT = START_DELAY_W'(START_DELAY - 1);
    localparam logic [START_DELAY_W-1:0] CNT_ZERO = {START_DELAY_W{1'b0}};
    localparam logic [START_DELAY_W-1:0] CNT_ONE  = {{(START_DELAY_W-1){1'b0}}, 1'b1};

    logic [START_DELAY_W-1:0] cnt_r;

    assign fire = count_en && (cnt_r == LAST_CNT);

    // Counter restarts whenever counting is not enabled, so each BOOT/RESTART visit starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
            pulse <= 1'b0;
        end else begin
            pulse <= fire;
            if (!count_en || fire) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/text_load_sequencer.sv
// Text RAM port owner and start/stop controller of the MC14500B handshake ring.
// Optional upload checksum checking is enabled by defining TEXT_LOAD_CHECKSUM_EN.
module text_load_sequencer
    import text_load_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 12,
    parameter int START_DELAY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    text_load_sequencer_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    seq_state_t            state_r, next_state_s;
    logic                  count_en_s, fire_s;
    logic                  accept_s, write_s, last_s, load_entry_s, csum_bad_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s, ram_waddr_r, ram_waddr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_r, ram_wdata_s;
    logic                  full_r, full_next_s;
    logic                  ram_req_r, ram_req_s, pc_clear_r, pc_clear_s;
    logic                  hold_r, hold_s, load_ready_r, load_ready_s;
    logic                  ram_we_r, ram_we_s, overflow_r, overflow_s;

    // A load_valid seen in BOOT takes priority over the pending start pulse.
    assign count_en_s = ((state_r == BOOT) && !bus.load_valid) || (state_r == RESTART);

    start_pulser #(.START_DELAY(START_DELAY)) u_start_pulser (
        .clk      (clk),
        .reset    (reset),
        .count_en (count_en_s),
        .fire     (fire_s),
        .pulse    (bus.core_start)
    );

    assign accept_s = (state_r == LOAD) && bus.load_valid;
    assign write_s  = accept_s && !full_r;
    assign last_s   = accept_s && bus.load_last;

`ifdef TEXT_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_r, csum_s;
    logic                  csum_err_r, csum_err_s;

    assign csum_bad_s = (csum_r ^ bus.load_word) != bus.load_csum;

    // Running XOR of every accepted word, including dropped ones, cleared on LOAD entry.
    always_comb begin
        csum_s     = csum_r;
        csum_err_s = csum_err_r;
        if (load_entry_s) begin
            csum_s     = DATA_ZERO;
            csum_err_s = 1'b0;
        end else if (accept_s) begin
            csum_s = csum_r ^ bus.load_word;
            if (bus.load_last && csum_bad_s) begin
                csum_err_s = 1'b1;
            end else begin
                csum_err_s = csum_err_r;
            end
        end else begin
            csum_s = csum_r;
        end
    end

    // Checksum accumulator and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r     <= DATA_ZERO;
            csum_err_r <= 1'b0;
        end else begin
            csum_r     <= csum_s;
            csum_err_r <= csum_err_s;
        end
    end

    assign bus.csum_err = csum_err_r;
`else
    logic unused_csum_s;
    assign unused_csum_s = ^bus.load_csum;
    assign csum_bad_s    = 1'b0;
    assign bus.csum_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a fetch token that meets an upload request is absorbed, never forwarded.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            BOOT: begin
                if (bus.load_valid)  next_state_s = LOAD;
                else if (fire_s)     next_state_s = RUN;
                else                 next_state_s = BOOT;
            end
            RUN: begin
                if (bus.load_valid && bus.fetch_req) next_state_s = LOAD;
                else if (bus.load_valid)             next_state_s = DRAIN;
                else                                 next_state_s = RUN;
            end
            DRAIN: begin
                if (bus.fetch_req) next_state_s = LOAD;
                else               next_state_s = DRAIN;
            end
            LOAD: begin
                if (last_s && csum_bad_s) next_state_s = ERROR;
                else if (last_s)          next_state_s = RESTART;
                else                      next_state_s = LOAD;
            end
            RESTART: begin
                if (fire_s) next_state_s = RUN;
                else        next_state_s = RESTART;
            end
            ERROR: begin
                if (bus.load_valid) next_state_s = LOAD;
                else                next_state_s = ERROR;
            end
            default: next_state_s = BOOT;
        endcase
    end

    // Output and datapath next values; outputs are registered from the next state.
    always_comb begin
        load_entry_s = (state_r != LOAD) && (next_state_s == LOAD);
        ram_req_s    = (state_r == RUN) && bus.fetch_req && !bus.load_valid;
        pc_clear_s   = (next_state_s == RESTART) && (state_r != RESTART);
        hold_s       = next_state_s != RUN;
        load_ready_s = next_state_s == LOAD;
        ram_we_s     = write_s;
        addr_next_s  = addr_r;
        full_next_s  = full_r;
        overflow_s   = overflow_r;
        if (load_entry_s || last_s) begin
            addr_next_s = ADDR_ZERO;
            full_next_s = 1'b0;
        end else if (write_s) begin
            addr_next_s = addr_r + ADDR_ONE;
            full_next_s = addr_r == ADDR_TOP;
        end else begin
            addr_next_s = addr_r;
        end
        if (load_entry_s) begin
            overflow_s = 1'b0;
        end else if (accept_s && full_r) begin
            overflow_s = 1'b1;
        end else begin
            overflow_s = overflow_r;
        end
        ram_waddr_s = write_s ? addr_r : addr_next_s;
        ram_wdata_s = write_s ? bus.load_word : ram_wdata_r;
    end

    // Output and write-pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r       <= ADDR_ZERO;
            full_r       <= 1'b0;
            ram_req_r    <= 1'b0;
            pc_clear_r   <= 1'b0;
            hold_r       <= 1'b1;
            load_ready_r <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_waddr_r  <= ADDR_ZERO;
            ram_wdata_r  <= DATA_ZERO;
            overflow_r   <= 1'b0;
        end else begin
            addr_r       <= addr_next_s;
            full_r       <= full_next_s;
            ram_req_r    <= ram_req_s;
            pc_clear_r   <= pc_clear_s;
            hold_r       <= hold_s;
            load_ready_r <= load_ready_s;
            ram_we_r     <= ram_we_s;
            ram_waddr_r  <= ram_waddr_s;
            ram_wdata_r  <= ram_wdata_s;
            overflow_r   <= overflow_s;
        end
    end

    assign bus.ram_req    = ram_req_r;
    assign bus.pc_clear   = pc_clear_r;
    assign bus.core_hold  = hold_r;
    assign bus.busy       = hold_r;
    assign bus.load_ready = load_ready_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_waddr  = ram_waddr_r;
    assign bus.ram_wdata  = ram_wdata_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_text_load_sequencer.sv
// Directed bench for text_load_sequencer: cycle-level reference model plus literal timing checks.
module tb_text_load_sequencer;
    localparam int AW    = 8;
    localparam int DW    = 12;
    localparam int SD    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef TEXT_LOAD_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int PH_BOOT = 0, PH_RUN = 1, PH_DRAIN = 2, PH_LOAD = 3, PH_RESTART = 4, PH_ERROR = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_load_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    text_load_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_DELAY(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, errors = 0, cyc = 0, n_writes = 0;

    // Reference model: phase of the ring, cycles spent waiting to start, words written so far.
    int ph = PH_BOOT, m_cnt = 0, m_ptr = 0, m_xor = 0, e_waddr = 0, e_wdata = 0;
    logic e_req = 1'b0, e_start = 1'b0, e_pcc = 1'b0, e_we = 1'b0, e_ovf = 1'b0, e_cerr = 1'b0;

    task automatic enter_load();
        ph <= PH_LOAD; m_ptr <= 0; m_xor <= 0; m_cnt <= 0; e_ovf <= 1'b0; e_cerr <= 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= PH_BOOT; m_cnt <= 0; m_ptr <= 0; m_xor <= 0; e_waddr <= 0; e_wdata <= 0;
            e_req <= 1'b0; e_start <= 1'b0; e_pcc <= 1'b0; e_we <= 1'b0; e_ovf <= 1'b0; e_cerr <= 1'b0;
        end else begin
            e_req <= 1'b0; e_start <= 1'b0; e_pcc <= 1'b0; e_we <= 1'b0;
            case (ph)
                PH_BOOT, PH_RESTART: begin
                    if (ph == PH_BOOT && bus.load_valid) enter_load();
                    else if (m_cnt + 1 == SD) begin e_start <= 1'b1; ph <= PH_RUN; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                end
                PH_RUN: begin
                    if (bus.load_valid && bus.fetch_req) enter_load();
                    else if (bus.load_valid) ph <= PH_DRAIN;
                    else e_req <= bus.fetch_req;
                end
                PH_DRAIN: if (bus.fetch_req) enter_load();
                PH_LOAD: if (bus.load_valid) begin
                    if (m_ptr < DEPTH) begin
                        e_we <= 1'b1; e_waddr <= m_ptr; e_wdata <= int'(bus.load_word); m_ptr <= m_ptr + 1;
                    end else e_ovf <= 1'b1;
                    m_xor <= m_xor ^ int'(bus.load_word);
                    if (bus.load_last) begin
                        m_ptr <= 0;
                        if (CSUM_ON && ((m_xor ^ int'(bus.load_word)) != int'(bus.load_csum))) begin
                            e_cerr <= 1'b1; ph <= PH_ERROR;
                        end else begin
                            e_pcc <= 1'b1; m_cnt <= 0; ph <= PH_RESTART;
                        end
                    end
                end
                PH_ERROR: if (bus.load_valid) enter_load();
                default: ph <= PH_BOOT;
            endcase
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check1("ram_req",    bus.ram_req,    e_req);
            check1("core_start", bus.core_start, e_start);
            check1("pc_clear",   bus.pc_clear,   e_pcc);
            check1("core_hold",  bus.core_hold,  ph != PH_RUN);
            check1("busy",       bus.busy,       ph != PH_RUN);
            check1("load_ready", bus.load_ready, ph == PH_LOAD);
            check1("ram_we",     bus.ram_we,     e_we);
            check1("overflow",   bus.overflow,   e_ovf);
            check1("csum_err",   bus.csum_err,   e_cerr);
            if (e_we) begin
                checkw("ram_waddr", 32'(bus.ram_waddr), 32'(e_waddr));
                checkw("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
            end
            if (bus.ram_we) n_writes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic l);
        logic r;
        bus.load_valid = 1'b1; bus.load_word = w; bus.load_last = l;
        for (int k = 0; k < 50; k++) begin
            r = bus.load_ready;
            tick();
            if (r) return;
        end
        checks++; errors++;
        $display("FAIL send_word_timeout actual=no_load_ready required=load_ready");
    endtask

    initial begin
        logic [DW-1:0] x;
        bus.fetch_req = 1'b0; bus.load_valid = 1'b0; bus.load_word = '0;
        bus.load_last = 1'b0; bus.load_csum = '0;
        tick(); tick();
        reset = 1'b0; cyc = 0;

        // Boot: start pulse exactly at cycle 3, busy drops with it.
        tick(); tick();
        check1("boot_start_c2", bus.core_start, 1'b0);
        tick();
        check1("boot_start_c3", bus.core_start, 1'b1);
        check1("boot_busy_c3", bus.busy, 1'b0);
        tick();
        check1("boot_start_c4", bus.core_start, 1'b0);

        // Fetch forwarding with one cycle latency.
        goto_cyc(10); bus.fetch_req = 1'b1; tick(); bus.fetch_req = 1'b0;
        check1("ram_req_c11", bus.ram_req, 1'b1);
        tick();
        check1("ram_req_c12", bus.ram_req, 1'b0);
        goto_cyc(20); bus.fetch_req = 1'b1; tick(); bus.fetch_req = 1'b0;
        check1("ram_req_c21", bus.ram_req, 1'b1);

        // Upload through DRAIN: token at 34 absorbed, two words, restart.
        goto_cyc(30);
        bus.load_valid = 1'b1; bus.load_word = 12'h123; bus.load_csum = 12'h575;
        tick();
        check1("drain_hold_c31", bus.core_hold, 1'b1);
        check1("drain_ready_c31", bus.load_ready, 1'b0);
        goto_cyc(34); bus.fetch_req = 1'b1; tick(); bus.fetch_req = 1'b0;
        check1("absorbed_c35", bus.ram_req, 1'b0);
        check1("ready_c35", bus.load_ready, 1'b1);
        tick();
        check1("we_c36", bus.ram_we, 1'b1);
        checkw("waddr_c36", 32'(bus.ram_waddr), 32'h0);
        checkw("wdata_c36", 32'(bus.ram_wdata), 32'h123);
        bus.load_word = 12'h456; bus.load_last = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        checkw("waddr_c37", 32'(bus.ram_waddr), 32'h1);
        checkw("wdata_c37", 32'(bus.ram_wdata), 32'h456);
        check1("pc_clear_c37", bus.pc_clear, 1'b1);
        tick(); tick();
        check1("restart_start_c39", bus.core_start, 1'b0);
        tick();
        check1("restart_start_c40", bus.core_start, 1'b1);

        // Overflow: 257 words, fetch and load_valid together go straight to LOAD.
        goto_cyc(50);
        bus.load_valid = 1'b1; bus.fetch_req = 1'b1; bus.load_word = 12'h003;
        tick(); bus.fetch_req = 1'b0;
        check1("direct_load_ready", bus.load_ready, 1'b1);
        check1("direct_no_req", bus.ram_req, 1'b0);
        n_writes = 0; x = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            x = x ^ DW'(i * 5 + 3);
            bus.load_csum = x;
            send_word(DW'(i * 5 + 3), i == DEPTH);
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        check1("overflow_set", bus.overflow, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        checkw("write_count", 32'(n_writes), 32'd256);
        check1("overflow_kept", bus.overflow, 1'b1);
        check1("overflow_run", bus.busy, 1'b0);

        // Reset in the middle of an upload.
        bus.load_valid = 1'b1; bus.load_word = 12'h0AA; tick();
        bus.fetch_req = 1'b1; tick(); bus.fetch_req = 1'b0;
        check1("overflow_cleared", bus.overflow, 1'b0);
        for (int i = 0; i < 5; i++) send_word(DW'(i + 12'h0A0), 1'b0);
        reset = 1'b1; bus.load_valid = 1'b0;
        #1;
        check1("rst_busy", bus.busy, 1'b1);
        check1("rst_hold", bus.core_hold, 1'b1);
        check1("rst_ready", bus.load_ready, 1'b0);
        check1("rst_we", bus.ram_we, 1'b0);
        checkw("rst_waddr", 32'(bus.ram_waddr), 32'h0);
        tick(); reset = 1'b0; cyc = 0;
        tick(); tick(); tick();
        check1("reboot_start_c3", bus.core_start, 1'b1);
        bus.load_valid = 1'b1; bus.load_word = 12'hABC; bus.load_csum = 12'h753; tick();
        bus.fetch_req = 1'b1; tick(); bus.fetch_req = 1'b0;
        send_word(12'hABC, 1'b0);
        checkw("reload_waddr0", 32'(bus.ram_waddr), 32'h0);
        send_word(12'hDEF, 1'b1);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        checkw("reload_waddr1", 32'(bus.ram_waddr), 32'h1);
        for (int i = 0; i < 4; i++) tick();

        // Upload straight out of BOOT, before any start pulse.
        reset = 1'b1; tick(); reset = 1'b0; cyc = 0;
        bus.load_valid = 1'b1; bus.load_word = 12'h555; bus.load_csum = 12'h555;
        tick();
        check1("boot_load_ready", bus.load_ready, 1'b1);
        check1("boot_load_nostart", bus.core_start, 1'b0);
        send_word(12'h555, 1'b1);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        checkw("boot_load_waddr", 32'(bus.ram_waddr), 32'h0);
        tick(); tick(); tick();
        check1("boot_load_start", bus.core_start, 1'b1);

`ifdef TEXT_LOAD_CHECKSUM_EN
        // Checksum match restarts; mismatch parks in ERROR until the next upload.
        bus.load_valid = 1'b1; bus.fetch_req = 1'b1; bus.load_csum = 12'h0FF; tick(); bus.fetch_req = 1'b0;
        send_word(12'h00F, 1'b0); send_word(12'h0F0, 1'b1);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        check1("csum_ok_pc_clear", bus.pc_clear, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        bus.load_valid = 1'b1; bus.fetch_req = 1'b1; bus.load_csum = 12'h000; tick(); bus.fetch_req = 1'b0;
        send_word(12'h00F, 1'b0); send_word(12'h0F0, 1'b1);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        check1("csum_bad_err", bus.csum_err, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check1("error_hold", bus.core_hold, 1'b1);
        bus.load_valid = 1'b1; bus.load_word = 12'h001; tick();
        check1("error_exit_clear", bus.csum_err, 1'b0);
        bus.load_csum = 12'h001; send_word(12'h001, 1'b1);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`endif

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_load_sequencer.md
Name: text_load_sequencer

Overview:
- Owns the program (text) RAM port and the start/stop of the MC14500B handshake ring.
- Normal operation: forwards the core's fetch request token to the text RAM.
- When a program upload arrives, parks the ring by absorbing the next fetch token, then streams words into text RAM from address 0.
- After the upload it resets the program counter and re-injects the start token, taking over the power-on starter function.

Parameters:
- ADDR_WIDTH, 8: text RAM address width.
- DATA_WIDTH, 12: instruction word width (opcode + address).
- START_DELAY, 3: idle cycles between entering BOOT/RESTART and the start pulse; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- fetch_req  in  1  request token from the ring (synchronised req_in_text); single-cycle pulse.
- ram_req  out  1  token into text RAM req_prev; registered.
- core_start  out  1  single-cycle start token into text RAM req_prev, ORed externally with ram_req.
- pc_clear  out  1  single-cycle program counter / ICU clear pulse.
- core_hold  out  1  high while the ring is parked.
- load_valid  in  1  upload word present.
- load_word  in  DATA_WIDTH  upload word.
- load_last  in  1  qualifies the final word, valid with load_valid.
- load_ready  out  1  sequencer accepts load_word this cycle.
- ram_we  out  1  text RAM write strobe.
- ram_waddr  out  ADDR_WIDTH  write address.
- ram_wdata  out  DATA_WIDTH  write data.
- load_csum  in  DATA_WIDTH  expected XOR checksum (optional feature).
- busy  out  1  high in any state other than RUN.
- overflow  out  1  sticky: the upload exceeded RAM depth.
- csum_err  out  1  sticky checksum mismatch (optional feature).

Behaviour:
- Reset values: state=BOOT, delay counter=0, ram_waddr=0, and every other output 0 except busy=1 and core_hold=1.
- States: BOOT, RUN, DRAIN, LOAD, RESTART, ERROR.
- BOOT:
  - Count START_DELAY cycles, then pulse core_start for 1 cycle and go to RUN.
  - If load_valid=1 during BOOT, go to LOAD directly; no token is in flight.
- RUN:
  - ram_req = fetch_req delayed by one register stage (latency 1 cycle).
  - load_valid=1 moves to DRAIN. The word is not yet accepted (load_ready=0).
  - If fetch_req and load_valid arrive in the same cycle, the fetch token is absorbed (not forwarded) and the state goes straight to LOAD.
- DRAIN:
  - core_hold=1.
  - Wait for the next fetch_req pulse; absorb it (ram_req stays 0), then go to LOAD.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1: ram_we=1, ram_wdata=load_word, ram_waddr=current address, and the address increments after the write (registered outputs, 1-cycle write latency).
  - Address wrap: after writing address 2^ADDR_WIDTH-1, further words are accepted but dropped (ram_we=0) and overflow is set.
  - load_last with load_valid: write that word, clear ram_waddr to 0, go to RESTART.
- RESTART:
  - Pulse pc_clear on the first cycle.
  - Count START_DELAY cycles, pulse core_start, go to RUN, drop core_hold.
  - load_valid in RESTART is ignored (load_ready=0) until RUN.
- Stickies: overflow and csum_err clear on reset or on entry to LOAD.
- Reset mid-upload: everything returns to BOOT and the partially written program is retained in RAM. A fresh upload restarts from address 0.
- Never more than one token in the ring: core_start is issued only from BOOT/RESTART, which a parked ring guarantees.

Optional Feature:
- Macro TEXT_LOAD_CHECKSUM_EN.
- Defined:
  - Running XOR of accepted words; cleared on entry to LOAD.
  - On load_last, compare the running XOR, including the last word, against load_csum.
  - Mismatch: set csum_err, go to ERROR instead of RESTART. ERROR holds the ring (core_hold=1) with no start pulse and leaves only on load_valid, which goes to LOAD.
- Undefined: load_csum is ignored, csum_err is tied to 0, and ERROR is unreachable.

Decomposition:
- Shared package text_load_pkg:
  - state enum seq_state_t {BOOT, RUN, DRAIN, LOAD, RESTART, ERROR}.
  - constant START_DELAY_W = 4.
- Sub-module start_pulser: delay counter plus single-cycle pulse generator, instantiated once and triggered from BOOT and RESTART.

Test Plan:
- Reset release, no upload -> core_start high exactly one cycle at cycle START_DELAY (3) after reset deassertion; busy falls the same cycle.
- RUN, fetch_req pulses at cycles 10 and 20 -> ram_req at cycles 11 and 21, each 1 cycle wide.
- RUN, load_valid rises at cycle 30, fetch_req at 34 -> no ram_req at 35; load_ready rises at 35; words 0x123, 0x456 (last) go to addresses 0 and 1; pc_clear pulses, then core_start 3 cycles later.
- Upload of 257 words with ADDR_WIDTH=8 -> 256 writes (addresses 0..255), word 257 dropped, overflow=1 until the next LOAD entry.
- Reset asserted mid-LOAD after 5 words -> all outputs at reset values immediately (async); BOOT start pulse follows; a new upload writes from address 0.
- With TEXT_LOAD_CHECKSUM_EN: words 0x00F, 0x0F0 (last), load_csum=0x0FF -> RESTART. Same words with load_csum=0x000 -> csum_err=1, ERROR, no core_start.
